// File: rtl/ibuf_pingpong_sched.sv
`timescale 1ns/1ps
// ibuf_pingpong_sched
//   Tile scheduler for the ping-pong input buffer in front of the depthwise
//   data router. It alternates the external loader between the two buffer
//   halves, starts one compute block (blkend) per filled half and frees the
//   half again once the buffer interface controller reports completion, so
//   the load of tile i+1 overlaps the compute of tile i.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start, num_tiles      layer start pulse (accepted in IDLE) and tile count
//   load_req/sel/tile     loader command pulse, target half, tile index
//   load_done             loader completion pulse
//   blkend/comp_sel/tile  compute start pulse, half being read, tile index
//   comp_done             compute completion pulse; the half may be refilled
//   busy, done            layer running; one-cycle end-of-layer pulse
module ibuf_pingpong_sched #(
  parameter int unsigned TILE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  output logic              load_req,
  output logic              load_sel,
  output logic [TILE_W-1:0] load_tile,
  input  logic              load_done,
  output logic              blkend,
  output logic              comp_sel,
  output logic [TILE_W-1:0] comp_tile,
  input  logic              comp_done,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  typedef enum logic [1:0] {EMPTY, LOADING, FULL, COMPUTING} half_t;

  localparam logic [TILE_W-1:0] ONE = TILE_W'(1);

  state_t            state_q, state_d;
  half_t             half_q [2];
  half_t             half_d [2];
  logic [TILE_W-1:0] ntiles_q, ntiles_d;
  logic [TILE_W-1:0] load_cnt_q, load_cnt_d;
  logic [TILE_W-1:0] comp_cnt_q, comp_cnt_d;
  logic              load_ptr_q, load_ptr_d;
  logic              comp_ptr_q, comp_ptr_d;
  logic              load_pend_q, load_pend_d;
  logic              comp_pend_q, comp_pend_d;
  logic              load_req_d, load_sel_d, blkend_d, comp_sel_d;
  logic              busy_d, done_d;
  logic [TILE_W-1:0] load_tile_d, comp_tile_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      half_q[0]   <= EMPTY;
      half_q[1]   <= EMPTY;
      ntiles_q    <= '0;
      load_cnt_q  <= '0;
      comp_cnt_q  <= '0;
      load_ptr_q  <= 1'b0;
      comp_ptr_q  <= 1'b0;
      load_pend_q <= 1'b0;
      comp_pend_q <= 1'b0;
      load_req    <= 1'b0;
      load_sel    <= 1'b0;
      load_tile   <= '0;
      blkend      <= 1'b0;
      comp_sel    <= 1'b0;
      comp_tile   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q[0]   <= half_d[0];
      half_q[1]   <= half_d[1];
      ntiles_q    <= ntiles_d;
      load_cnt_q  <= load_cnt_d;
      comp_cnt_q  <= comp_cnt_d;
      load_ptr_q  <= load_ptr_d;
      comp_ptr_q  <= comp_ptr_d;
      load_pend_q <= load_pend_d;
      comp_pend_q <= comp_pend_d;
      load_req    <= load_req_d;
      load_sel    <= load_sel_d;
      load_tile   <= load_tile_d;
      blkend      <= blkend_d;
      comp_sel    <= comp_sel_d;
      comp_tile   <= comp_tile_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    half_d[0]   = half_q[0];
    half_d[1]   = half_q[1];
    ntiles_d    = ntiles_q;
    load_cnt_d  = load_cnt_q;
    comp_cnt_d  = comp_cnt_q;
    load_ptr_d  = load_ptr_q;
    comp_ptr_d  = comp_ptr_q;
    load_pend_d = load_pend_q;
    comp_pend_d = comp_pend_q;
    load_req_d  = 1'b0;
    blkend_d    = 1'b0;
    load_sel_d  = load_sel;
    load_tile_d = load_tile;
    comp_sel_d  = comp_sel;
    comp_tile_d = comp_tile;

    case (state_q)
      IDLE: begin
        if (start) begin
          ntiles_d    = num_tiles;
          half_d[0]   = EMPTY;
          half_d[1]   = EMPTY;
          load_cnt_d  = '0;
          comp_cnt_d  = '0;
          load_ptr_d  = 1'b0;
          comp_ptr_d  = 1'b0;
          load_pend_d = 1'b0;
          comp_pend_d = 1'b0;
          load_sel_d  = 1'b0;
          load_tile_d = '0;
          comp_sel_d  = 1'b0;
          comp_tile_d = '0;
          state_d     = (num_tiles == '0) ? FIN : RUN;
        end
      end

      RUN: begin
        // Completions only touch the next-state copy; issue below looks at
        // half_q, so a freed/filled half is reusable one cycle later.
        if (load_done && load_pend_q) begin
          half_d[load_sel] = FULL;
          load_pend_d      = 1'b0;
        end
        if (comp_done && comp_pend_q) begin
          half_d[comp_sel] = EMPTY;
          comp_pend_d      = 1'b0;
          comp_cnt_d       = comp_cnt_q + ONE;
          comp_tile_d      = comp_tile + ONE;
        end

        if (comp_cnt_q == ntiles_q) begin
          state_d = FIN;
        end else begin
          if (!load_pend_q && (load_cnt_q < ntiles_q) && (half_q[load_ptr_q] == EMPTY)) begin
            load_req_d         = 1'b1;
            load_sel_d         = load_ptr_q;
            load_tile_d        = load_cnt_q;
            half_d[load_ptr_q] = LOADING;
            load_ptr_d         = ~load_ptr_q;
            load_cnt_d         = load_cnt_q + ONE;
            load_pend_d        = 1'b1;
          end
          if (!comp_pend_q && (half_q[comp_ptr_q] == FULL)) begin
            blkend_d           = 1'b1;
            comp_sel_d         = comp_ptr_q;
            half_d[comp_ptr_q] = COMPUTING;
            comp_ptr_d         = ~comp_ptr_q;
            comp_pend_d        = 1'b1;
          end
        end
      end

      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

endmodule

// File: tb/tb_ibuf_pingpong_sched.sv
`timescale 1ns/1ps
// Bench for ibuf_pingpong_sched: a tile-count model predicts every output on
// every cycle; directed layers add literal timing and ordering expectations.
module tb_ibuf_pingpong_sched;
  localparam int unsigned TW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic          load_req, load_sel, blkend, comp_sel, busy, done;
  logic [TW-1:0] load_tile, comp_tile;
  logic          load_done, comp_done;
  logic          resp_ld = 1'b0, resp_cd = 1'b0, man_ld = 1'b0, man_cd = 1'b0;

  assign load_done = resp_ld | man_ld;
  assign comp_done = resp_cd | man_cd;

  always #5 clk = ~clk;

  ibuf_pingpong_sched #(.TILE_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_tiles (num_tiles),
    .load_req  (load_req),
    .load_sel  (load_sel),
    .load_tile (load_tile),
    .load_done (load_done),
    .blkend    (blkend),
    .comp_sel  (comp_sel),
    .comp_tile (comp_tile),
    .comp_done (comp_done),
    .busy      (busy),
    .done      (done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int st_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Model: tile t always lives in half t%2. Loads and computes proceed in
  // tile order, so counts of issued/finished tiles describe the whole state.
  int m_phase = 0;  // 0 idle, 1 run, 2 fin
  int m_nt = 0, m_issued = 0, m_loaded = 0, m_started = 0, m_computed = 0;
  int p_issued, p_loaded, p_started, p_computed;
  bit lo, co;
  logic          e_load_req = 1'b0, e_load_sel = 1'b0, e_blkend = 1'b0, e_comp_sel = 1'b0;
  logic          e_busy = 1'b0, e_done = 1'b0;
  logic [TW-1:0] e_load_tile = '0, e_comp_tile = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_nt = 0; m_issued = 0; m_loaded = 0; m_started = 0; m_computed = 0;
      e_load_req = 1'b0; e_load_sel = 1'b0; e_load_tile = '0;
      e_blkend = 1'b0; e_comp_sel = 1'b0; e_comp_tile = '0;
      e_busy = 1'b0; e_done = 1'b0;
    end else begin
      p_issued = m_issued; p_loaded = m_loaded; p_started = m_started; p_computed = m_computed;
      lo = p_issued > p_loaded;
      co = p_started > p_computed;
      e_load_req = 1'b0;
      e_blkend = 1'b0;
      case (m_phase)
        0: if (start) begin
          m_nt = int'(num_tiles);
          m_issued = 0; m_loaded = 0; m_started = 0; m_computed = 0;
          e_load_sel = 1'b0; e_load_tile = '0; e_comp_sel = 1'b0; e_comp_tile = '0;
          m_phase = (m_nt == 0) ? 2 : 1;
        end
        1: begin
          if (load_done && lo) m_loaded++;
          if (comp_done && co) begin
            m_computed++;
            e_comp_tile = TW'(m_computed);
          end
          if (p_computed == m_nt) m_phase = 2;
          else begin
            // Half of tile p_issued is free once tile p_issued-2 is finished.
            if (!lo && p_issued < m_nt && (p_issued < 2 || p_computed >= p_issued - 1)) begin
              e_load_req = 1'b1;
              e_load_sel = p_issued[0];
              e_load_tile = TW'(p_issued);
              m_issued++;
            end
            if (!co && p_started < p_loaded) begin
              e_blkend = 1'b1;
              e_comp_sel = p_started[0];
              m_started++;
            end
          end
        end
        default: m_phase = 0;
      endcase
      e_busy = (m_phase == 1);
      e_done = (m_phase == 2);
    end
  end

  always @(negedge clk) begin
    chk("load_req",  int'(load_req),  int'(e_load_req));
    chk("load_sel",  int'(load_sel),  int'(e_load_sel));
    chk("load_tile", int'(load_tile), int'(e_load_tile));
    chk("blkend",    int'(blkend),    int'(e_blkend));
    chk("comp_sel",  int'(comp_sel),  int'(e_comp_sel));
    chk("comp_tile", int'(comp_tile), int'(e_comp_tile));
    chk("busy",      int'(busy),      int'(e_busy));
    chk("done",      int'(done),      int'(e_done));
  end

  // DUT event log (edge number after which each pulse was visible).
  int lr_cyc[$], lr_sel[$], lr_tile[$], be_cyc[$], be_sel[$], dn_cyc[$];
  int ld_edge[$], cd_edge[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (load_req) begin
        lr_cyc.push_back(cyc); lr_sel.push_back(int'(load_sel)); lr_tile.push_back(int'(load_tile));
      end
      if (blkend) begin
        be_cyc.push_back(cyc); be_sel.push_back(int'(comp_sel));
      end
      if (done) dn_cyc.push_back(cyc);
    end
  end

  // Loader / compute responders, paced from the model's command pulses.
  int ld_lat = 3, cd_lat = 8, ld_cnt = 0, cd_cnt = 0;
  bit auto_ld = 1'b1, auto_cd = 1'b1;

  always @(negedge clk) begin
    resp_ld = 1'b0;
    resp_cd = 1'b0;
    if (rst) begin
      ld_cnt = 0;
      cd_cnt = 0;
    end else begin
      if (ld_cnt > 0) begin
        ld_cnt--;
        if (ld_cnt == 0) begin resp_ld = 1'b1; ld_edge.push_back(cyc + 1); end
      end
      if (e_load_req && auto_ld) begin
        if (ld_lat <= 1) begin resp_ld = 1'b1; ld_edge.push_back(cyc + 1); end
        else ld_cnt = ld_lat - 1;
      end
      if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) begin resp_cd = 1'b1; cd_edge.push_back(cyc + 1); end
      end
      if (e_blkend && auto_cd) begin
        if (cd_lat <= 1) begin resp_cd = 1'b1; cd_edge.push_back(cyc + 1); end
        else cd_cnt = cd_lat - 1;
      end
    end
  end

  task automatic clear_logs();
    lr_cyc.delete(); lr_sel.delete(); lr_tile.delete();
    be_cyc.delete(); be_sel.delete(); dn_cyc.delete();
    ld_edge.delete(); cd_edge.delete();
  endtask

  // Runs one layer; mid_start > 0 pulses a stray start while running,
  // fin_start pulses one while done is high.
  task automatic run_layer(input int nt, input int ll, input int cl,
                           input int mid_start, input bit fin_start);
    bit got;
    @(negedge clk);
    clear_logs();
    ld_lat = ll;
    cd_lat = cl;
    num_tiles = TW'(nt);
    start = 1'b1;
    st_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    got = done;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (mid_start > 0 && i == mid_start) begin
        start = 1'b1;
        num_tiles = TW'(7);
      end
      got = done;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL layer_timeout: done not seen, nt=%0d", nt);
    end
    start = fin_start;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single tile, stray start during FIN.
    run_layer(1, 5, 10, 0, 1'b1);
    chk("t1_load_req_count", lr_cyc.size(), 1);
    chk("t1_load_sel",       qget(lr_sel, 0), 0);
    chk("t1_load_tile",      qget(lr_tile, 0), 0);
    chk("t1_blkend_count",   be_cyc.size(), 1);
    chk("t1_comp_sel",       qget(be_sel, 0), 0);
    chk("t1_done_count",     dn_cyc.size(), 1);
    chk("t1_first_req_lat",  qget(lr_cyc, 0) - st_edge, 1);
    chk("t1_done_after_cd",  qget(dn_cyc, 0) - qget(cd_edge, 0), 1);
    chk("t1_done_lat",       qget(dn_cyc, 0) - st_edge, 18);

    // Overlap.
    run_layer(4, 3, 8, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_load_sel%0d", i),  qget(lr_sel, i), i % 2);
      chk($sformatf("t2_load_tile%0d", i), qget(lr_tile, i), i);
      chk($sformatf("t2_comp_sel%0d", i),  qget(be_sel, i), i % 2);
    end
    chk("t2_req2_after_cd0", qget(lr_cyc, 2) - qget(cd_edge, 0), 1);
    chk("t2_done_count",     dn_cyc.size(), 1);
    chk("t2_done_lat",       qget(dn_cyc, 0) - st_edge, 41);

    // Slow loader, stray start while running.
    run_layer(3, 12, 2, 10, 1'b0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t3_blkend_after_ld%0d", i), qget(be_cyc, i) - qget(ld_edge, i), 1);
    chk("t3_load_req_count", lr_cyc.size(), 3);
    chk("t3_done_lat",       qget(dn_cyc, 0) - st_edge, 43);

    // Simultaneous load_done/comp_done (both at edge 10 relative to start).
    run_layer(4, 4, 4, 0, 1'b0);
    chk("t4_blkend1_edge",   qget(be_cyc, 1) - st_edge, 11);
    chk("t4_load_req2_edge", qget(lr_cyc, 2) - st_edge, 11);
    chk("t4_done_lat",       qget(dn_cyc, 0) - st_edge, 26);

    // Zero tiles, then spurious handshakes in IDLE.
    run_layer(0, 3, 3, 0, 1'b0);
    chk("t5_load_req_count", lr_cyc.size(), 0);
    chk("t5_blkend_count",   be_cyc.size(), 0);
    chk("t5_done_count",     dn_cyc.size(), 1);
    chk("t5_done_lat",       qget(dn_cyc, 0) - st_edge, 0);
    @(negedge clk);
    man_ld = 1'b1;
    man_cd = 1'b1;
    @(negedge clk);
    man_ld = 1'b0;
    man_cd = 1'b0;
    repeat (3) @(negedge clk);

    // Async reset while a load is outstanding, late load_done, restart.
    auto_ld = 1'b0;
    @(negedge clk);
    clear_logs();
    num_tiles = TW'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = load_req;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL t6_load_req_timeout: load_req not seen");
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_load_req",  int'(load_req), 0);
    chk("t6_rst_load_sel",  int'(load_sel), 0);
    chk("t6_rst_load_tile", int'(load_tile), 0);
    chk("t6_rst_busy",      int'(busy), 0);
    chk("t6_rst_done",      int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    man_ld = 1'b1;
    @(negedge clk);
    man_ld = 1'b0;
    repeat (3) @(negedge clk);
    auto_ld = 1'b1;
    run_layer(4, 3, 8, 0, 1'b0);
    chk("t6_restart_sel",      qget(lr_sel, 0), 0);
    chk("t6_restart_tile",     qget(lr_tile, 0), 0);
    chk("t6_restart_req_lat",  qget(lr_cyc, 0) - st_edge, 1);
    chk("t6_restart_req_count", lr_cyc.size(), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
